// File: rtl/psg_bus_master.sv
// psg_bus_master: queued command initiator for the PSG BDIR/BC register bus.
// Read support is compiled in when PSG_BUS_READ_EN is defined; otherwise every command is a write.
module psg_bus_master #(
  parameter int DEPTH     = 4,
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  output logic       busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int MAXC  = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0]    PH_LOAD  = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0]    GAP_LOAD = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WRITE, S_READ, S_GAP} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  cmd_t             cur;
  cmd_t             sel;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  state_t           state;
  state_t           data_st;
  logic [9:0]       data_bus;
  logic [CW-1:0]    cnt;
  logic [7:0]       last_addr;
  logic             last_valid;
  logic             push;
  logic             pop;
  logic             fsm_to_idle;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // The data phase is taken from the FIFO head when skipping the address
  // phase straight out of IDLE, and from the latched command after ADDR.
  always_comb begin
    sel      = (state == S_IDLE) ? head : cur;
    data_st  = S_WRITE;
    data_bus = {2'b10, sel.data};
`ifdef PSG_BUS_READ_EN
    if (sel.rd) begin
      data_st  = S_READ;
      data_bus = {2'b01, 8'h00};
    end
`endif
  end

`ifndef PSG_BUS_READ_EN
  logic unused_bits;
  assign unused_bits = ^{sel.rd, DI};
`endif

  always_comb begin
    fsm_to_idle = 1'b0;
    case (state)
      S_IDLE:          fsm_to_idle = !pop;
      S_WRITE, S_READ: fsm_to_idle = (cnt == '0) && (GAP_CYC == 0);
      S_GAP:           fsm_to_idle = (cnt == '0);
      default:         fsm_to_idle = 1'b0;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it was written, and the pointers/count that qualify it are reset.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur        <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      BDIR       <= 1'b0;
      BC         <= 1'b0;
      DO         <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      cmd_ready <= (count_next != FULL);
      busy      <= (count_next != '0) || !fsm_to_idle;

      case (state)
        S_IDLE: begin
          if (pop) begin
            cur <= head;
            cnt <= PH_LOAD;
            if (last_valid && head.addr == last_addr) begin
              state          <= data_st;
              {BDIR, BC, DO} <= data_bus;
            end else begin
              state          <= S_ADDR;
              {BDIR, BC, DO} <= {2'b11, head.addr};
            end
          end else begin
            {BDIR, BC, DO} <= '0;
          end
        end
        S_ADDR: begin
          if (cnt == '0) begin
            last_addr      <= cur.addr;
            last_valid     <= 1'b1;
            cnt            <= PH_LOAD;
            state          <= data_st;
            {BDIR, BC, DO} <= data_bus;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRITE, S_READ: begin
          if (cnt == '0) begin
`ifdef PSG_BUS_READ_EN
            if (state == S_READ) begin
              rsp_valid <= 1'b1;
              rsp_data  <= DI;
            end
`endif
            {BDIR, BC, DO} <= '0;
            if (GAP_CYC > 0) begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0)
            state <= S_IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          state          <= S_IDLE;
          {BDIR, BC, DO} <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psg_bus_master.sv
// tb_psg_bus_master: directed steps with a bus/response scoreboard for psg_bus_master.
// Builds and checks the read path when PSG_BUS_READ_EN is defined.
module tb_psg_bus_master;

  localparam int DEPTH = 4;
  localparam int PHASE = 2;
  localparam int GAP   = 1;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] DI = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       BDIR;
  logic       BC;
  logic [7:0] DO;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected non-idle bus cycles {BDIR,BC,DO} and expected read responses, in order.
  logic [9:0] exp_q[$];
  logic [7:0] rsp_q[$];
  logic       m_last_valid = 1'b0;
  logic [7:0] m_last_addr = 8'h00;

  logic [9:0] t1_bus  [7];
  logic       t1_busy [7];

  psg_bus_master #(.DEPTH(DEPTH), .PHASE_CYC(PHASE), .GAP_CYC(GAP)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .BDIR      (BDIR),
    .BC        (BC),
    .DO        (DO),
    .DI        (DI),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard side: every active bus cycle and every response pulse is matched in order.
  always @(negedge CLK) begin
    if (RESET_n) begin
      if (BDIR || BC) begin
        logic [10:0] e;
        e = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 11'h000;
        check("bus_cycle", {1'b1, BDIR, BC, DO}, e);
      end
      if (rsp_valid) begin
        logic [8:0] r;
        r = (rsp_q.size() != 0) ? {1'b1, rsp_q.pop_front()} : 9'h000;
        check("rsp_pulse", {1'b1, rsp_data}, r);
      end
    end
  end

  task automatic push_cmd(input logic rd, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] di_exp);
    logic is_rd;
    int   waited;
`ifdef PSG_BUS_READ_EN
    is_rd = rd;
`else
    is_rd = 1'b0;
`endif
    if (!(m_last_valid && m_last_addr == a))
      repeat (PHASE) exp_q.push_back({2'b11, a});
    m_last_valid = 1'b1;
    m_last_addr  = a;
    repeat (PHASE) exp_q.push_back(is_rd ? {2'b01, 8'h00} : {2'b10, d});
    if (is_rd) rsp_q.push_back(di_exp);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_addr  = a;
    cmd_data  = d;
    waited    = 0;
    while (!cmd_ready && waited < 100) begin
      step(1);
      waited++;
    end
    check("push_accept", cmd_ready, 1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      step(1);
      n++;
    end
    check(tag, {busy, (exp_q.size() != 0), (rsp_q.size() != 0)}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values
    step(2);
    check("rst_bus",      {BDIR, BC, DO}, 10'h000);
    check("rst_rsp",      {rsp_valid, rsp_data}, 9'h000);
    check("rst_busy",     busy, 0);
    check("rst_cmdready", cmd_ready, 1);
    RESET_n = 1'b1;
    step(1);

    // Single write 07<-38: exact cycle timing from the push edge onwards
    t1_bus  = '{10'h000, 10'h307, 10'h307, 10'h238, 10'h238, 10'h000, 10'h000};
    t1_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    push_cmd(1'b0, 8'h07, 8'h38, 8'h00);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_bus_%0d", i), {BDIR, BC, DO}, t1_bus[i]);
      check($sformatf("t1_busy_%0d", i), busy, t1_busy[i]);
      if (i < 6) step(1);
    end
    wait_idle("t1_idle");

    // Same address twice: second access has no ADDR phase
    push_cmd(1'b0, 8'h08, 8'h0F, 8'h00);
    push_cmd(1'b0, 8'h08, 8'h0A, 8'h00);
    wait_idle("t2_idle");

    // Five back-to-back writes: FIFO fills after the fifth push, frees on the next pop
    for (int i = 0; i < 5; i++)
      push_cmd(1'b0, 8'h10 + 8'(i), 8'hA0 + 8'(i), 8'h00);
    check("t3_full", cmd_ready, 0);
    step(2);
    check("t3_full_held", cmd_ready, 0);
    step(1);
    check("t3_ready_after_pop", cmd_ready, 1);
    wait_idle("t3_idle");

`ifdef PSG_BUS_READ_EN
    // Reads: new address then same address (no ADDR phase)
    DI = 8'h5A;
    push_cmd(1'b1, 8'h0E, 8'h00, 8'h5A);
    wait_idle("t4_idle_a");
    check("t4_rsp_hold_a", rsp_data, 8'h5A);
    DI = 8'hC3;
    push_cmd(1'b1, 8'h0E, 8'h00, 8'hC3);
    wait_idle("t4_idle_b");
    check("t4_rsp_hold_b", rsp_data, 8'hC3);
`else
    // Read command executes as a write; no response ever
    DI = 8'h99;
    push_cmd(1'b1, 8'h03, 8'h44, 8'h00);
    wait_idle("t6_idle");
    check("t6_rsp", {rsp_valid, rsp_data}, 9'h000);
`endif

    // Reset in the middle of a write with two commands queued
    push_cmd(1'b0, 8'h09, 8'h1F, 8'h00);
    push_cmd(1'b0, 8'h09, 8'h20, 8'h00);
    push_cmd(1'b0, 8'h0A, 8'h21, 8'h00);
    n = 0;
    while (!(BDIR && !BC && DO == 8'h1F) && n < 50) begin
      step(1);
      n++;
    end
    check("t5_in_write", {BDIR, BC, DO}, 10'h21F);
    RESET_n = 1'b0;
    step(1);
    check("t5_rst_bus",   {BDIR, BC, DO}, 10'h000);
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_ready", cmd_ready, 1);
    check("t5_rst_rsp",   rsp_valid, 0);
    exp_q.delete();
    rsp_q.delete();
    m_last_valid = 1'b0;
    RESET_n = 1'b1;
    step(3);
    check("t5_flushed_busy", busy, 0);
    check("t5_flushed_bus",  {BDIR, BC, DO}, 10'h000);
    push_cmd(1'b0, 8'h09, 8'h10, 8'h00);
    step(1);
    check("t5_addr_reissued", {BDIR, BC, DO}, 10'h309);
    wait_idle("t5_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
